mul8_seq_ctrl: RTL and testbench

Sequencer that computes an unsigned 8x8 -> 16-bit product over four cycles, using one shared 4x4 combinational multiplier. It splits each operand into nibbles and multiplies one nibble pair per cycle. Each partial product is shifted and accumulated, and the result is presented with a valid/ready handshake. It sits between an operand producer (e.g. a filter or MAC stage) and the existing 4x4 multiplier datapath, trading throughput for area.

---
 rtl/mul_seq_pkg.sv | 28 ++
 rtl/top_multiplier.sv | 11 +
 rtl/mul8_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mul8_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants for the nibble-serial 8x8 multiplier sequencer
package mul_seq_pkg;

  // Controller state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Four nibble steps per product
  localparam int STEP_W = 2;

  // Left shift applied to each step's partial product before accumulation
  localparam int SH0 = 0;
  localparam int SH1 = 4;
  localparam int SH2 = 4;
  localparam int SH3 = 8;

  // Shift amount for a given step
  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    case (step)
      2'd0:    step_shift = 4'(SH0);
      2'd1:    step_shift = 4'(SH1);
      2'd2:    step_shift = 4'(SH2);
      default: step_shift = 4'(SH3);
    endcase
  endfunction

endpackage

// File: rtl/top_multiplier.sv
// rtl/top_multiplier.sv - shared 4x4 unsigned combinational multiplier
module top_multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  // Zero-extend both nibbles so the product is computed at full 8-bit width
  assign P = {4'd0, A} * {4'd0, B};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiply over four cycles on one 4x4 multiplier
module mul8_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int ZERO_SKIP = 0,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] P,
  output logic             busy
);

  // The accumulator and product path are sized for exactly 16 bits
  generate
    if (OUT_W != 16) begin : g_bad_out_w
      $error("mul8_seq_ctrl: OUT_W must be 16");
    end
  endgenerate

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [STEP_W-1:0] step;
  logic [7:0]        a_r;
  logic [7:0]        b_r;
  logic [15:0]       acc;
  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [7:0]        pp;
  logic [15:0]       sum;
  logic              accept;
  logic              zero_op;
  logic              last_step;

  assign accept    = in_valid & in_ready;
  assign zero_op   = (ZERO_SKIP != 0) && ((A == 8'd0) || (B == 8'd0));
  assign last_step = (step == {STEP_W{1'b1}});

  // Nibble select from registered operands: step bit0 picks A half, bit1 picks B half
  assign nib_a = step[0] ? a_r[7:4] : a_r[3:0];
  assign nib_b = step[1] ? b_r[7:4] : b_r[3:0];

  top_multiplier u_mult (
    .A (nib_a),
    .B (nib_b),
    .P (pp)
  );

  assign sum = acc + ({8'd0, pp} << step_shift(step));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE with out_ready may accept the next pair on the same edge
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs; out_ready feeds in_ready combinationally
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    busy     = (state == CALC) || (state == DONE);
  end

  // Operand capture, step counter, accumulator and result register.
  // A zero-skip pair enters CALC at the last step: with one operand entirely
  // zero every nibble product is zero, so the single CALC cycle yields P=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      step      <= '0;
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      if (accept) begin
        a_r  <= A;
        b_r  <= B;
        acc  <= '0;
        step <= zero_op ? {STEP_W{1'b1}} : '0;
      end else if (state == CALC) begin
        acc  <= sum;
        step <= step + STEP_W'(1);
        if (last_step) P <= OUT_W'(sum);
      end
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - directed and random checks for mul8_seq_ctrl
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  A, B;
  logic [15:0] P;
  logic        zs_in_valid, zs_in_ready, zs_out_valid, zs_out_ready, zs_busy;
  logic [7:0]  zs_A, zs_B;
  logic [15:0] zs_P;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.ZERO_SKIP(0), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  mul8_seq_ctrl #(.ZERO_SKIP(1), .OUT_W(16)) dut_zs (
    .clk(clk), .rst(rst), .in_valid(zs_in_valid), .in_ready(zs_in_ready),
    .A(zs_A), .B(zs_B), .out_valid(zs_out_valid), .out_ready(zs_out_ready),
    .P(zs_P), .busy(zs_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    zs_in_valid = 1'b0; zs_out_ready = 1'b0; zs_A = '0; zs_B = '0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_P", P, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: FF*FF, 4-cycle latency, in_ready low during CALC
    A = 8'hFF; B = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_calc_out_valid", out_valid, 0);
      check("t1_calc_in_ready", in_ready, 0);
      check("t1_calc_busy", busy, 1);
      tick();
    end
    check("t1_out_valid", out_valid, 1);
    check("t1_P", P, 16'hFE01);
    tick();
    check("t1_retired", out_valid, 0);

    // 2: 12*34 stalled by out_ready=0; in_valid during stall must be ignored
    A = 8'h12; B = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    A = 8'h99; B = 8'h99;
    repeat (4) tick();
    for (int k = 0; k < 6; k++) begin
      check("t2_hold_out_valid", out_valid, 1);
      check("t2_hold_P", P, 16'h03A8);
      check("t2_hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("t2_in_ready_comb", in_ready, 1);
    tick();
    check("t2_retired_out_valid", out_valid, 0);
    check("t2_retired_busy", busy, 0);
    check("t2_P_kept", P, 16'h03A8);

    // 3: back-to-back 0F*F0 then A5*5A, second accept on the retire edge
    A = 8'h0F; B = 8'hF0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    A = 8'hA5; B = 8'h5A;
    repeat (3) tick();
    check("t3_first_not_yet", out_valid, 0);
    tick();
    check("t3_first_valid", out_valid, 1);
    check("t3_first_P", P, 16'h0E10);
    check("t3_in_ready_done", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_second_accepted", busy, 1);
    check("t3_gap_out_valid", out_valid, 0);
    repeat (3) tick();
    check("t3_second_not_yet", out_valid, 0);
    tick();
    check("t3_second_valid", out_valid, 1);
    check("t3_second_P", P, 16'h3A02);
    tick();

    // 5: reset during step2 of 80*80, then 03*05 with no residue
    A = 8'h80; B = 8'h80; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_P", P, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    A = 8'h03; B = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t5_not_yet", out_valid, 0);
    tick();
    check("t5_out_valid", out_valid, 1);
    check("t5_P", P, 16'h000F);
    tick();

    // 4: zero operand, with and without zero-skip
    zs_A = 8'h03; zs_B = 8'h05; zs_in_valid = 1'b1; zs_out_ready = 1'b0;
    tick();
    zs_in_valid = 1'b0;
    repeat (4) tick();
    check("t4_zs_nonzero_P", zs_P, 16'h000F);
    check("t4_zs_nonzero_valid", zs_out_valid, 1);
    zs_out_ready = 1'b1;
    tick();
    zs_A = 8'h00; zs_B = 8'h77; zs_in_valid = 1'b1;
    tick();
    zs_in_valid = 1'b0;
    check("t4_zs_busy", zs_busy, 1);
    check("t4_zs_not_yet", zs_out_valid, 0);
    tick();
    check("t4_zs_valid", zs_out_valid, 1);
    check("t4_zs_P", zs_P, 0);
    tick();
    zs_A = 8'h5C; zs_B = 8'h00; zs_in_valid = 1'b1;
    tick();
    zs_in_valid = 1'b0;
    tick();
    check("t4_zs_b0_valid", zs_out_valid, 1);
    check("t4_zs_b0_P", zs_P, 0);
    tick();

    A = 8'h00; B = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t4_noskip_not_yet", out_valid, 0);
    tick();
    check("t4_noskip_valid", out_valid, 1);
    check("t4_noskip_P", P, 0);
    tick();

    // 6: random pairs with random stalls against a reference queue
    begin : t6
      logic [15:0] expq[$];
      logic [15:0] e;
      logic        ai, ao;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      in_valid = 1'b0;
      while (got < 1000 && cyc < 20000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid && sent < 1000 && $urandom_range(0, 7) != 0) begin
          A = 8'($urandom); B = 8'($urandom); in_valid = 1'b1;
        end
        #1;
        ai = in_valid && in_ready;
        ao = out_valid && out_ready;
        if (ao) begin
          if (expq.size() == 0) check("t6_spurious", 1, 0);
          else begin
            e = expq.pop_front();
            check("t6_P", P, e);
          end
          got++;
        end
        if (ai) begin
          expq.push_back(16'(A) * 16'(B));
          sent++;
        end
        tick();
        cyc++;
        if (ai) in_valid = 1'b0;
      end
      check("t6_count", got, 1000);
      check("t6_queue_empty", expq.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
